// File: rtl/sll_shifter_seq.sv
// sll_shifter_seq: multi-cycle 32-bit logical-left shifter for the ALU shift path.
// The operand is latched at acceptance, then one power-of-two stage (1,2,4,8,16)
// is applied per cycle. A start/busy/done handshake lets the ALU control FSM
// drive it like the multiplier/divider. Zero fill enters from the LSB side.
//
// state | meaning
// IDLE  | waiting for start with Signal == SLL
// SHIFT | applying stage 0..STAGES-1, one per clock
// DONE  | result valid, done pulse high; returns to IDLE next edge
module sll_shifter_seq #(
  parameter int          WIDTH  = 32,
  parameter int          STAGES = 5,
  parameter logic [5:0]  SLL    = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [5:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [4:0]       amt;
  logic [2:0]       stage;
  logic [4:0]       stage_dist;
  logic [WIDTH-1:0] acc_next;

  // Distance of the current stage and the accumulator after applying it.
  always_comb begin
    stage_dist = 5'd1 << stage;
    acc_next   = acc;
    if (amt[stage]) begin
      acc_next = acc << stage_dist;
    end
  end

  // Handshake FSM, operand/amount capture, stage sequencing and result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      amt     <= '0;
      stage   <= '0;
      dataOut <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (Signal == SLL)) begin
            acc   <= dataA;
            amt   <= shamt[4:0];
            stage <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          if (stage == LAST_STAGE) begin
            // Stage counter parks on the last stage rather than wrapping.
            dataOut <= acc_next;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            stage <= stage + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll_shifter_seq.sv
// Testbench for sll_shifter_seq: directed scenarios plus randomized traffic,
// all compared against a timeline-based reference model of the handshake.
module tb_sll_shifter_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [5:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  sll_shifter_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Signal  (Signal),
    .dataA   (dataA),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: an accepted op occupies a fixed 7-edge window
  // (accept, five shift edges, one DONE edge); the result is plain arithmetic.
  int          m_cnt  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_out  = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_out = '0;
    end else if (m_cnt == 0) begin
      m_done = 1'b0;
      if (start && Signal == 6'b000000) begin
        m_busy = 1'b1;
        m_cnt  = 1;
        m_pend = dataA << shamt[4:0];
      end
    end else begin
      m_cnt++;
      if (m_cnt == 6) begin
        m_done = 1'b1;
        m_out  = m_pend;
      end else if (m_cnt == 7) begin
        m_done = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("dataOut", dataOut, m_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat);
    bit seen = 0;
    int lat  = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat  = i;
        check({tag, "_res"}, dataOut, exp);
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [5:0] sh,
                    input logic [31:0] exp);
    start = 1'b1; Signal = 6'b000000; dataA = a; shamt = sh;
    tick();
    start = 1'b0;
    wait_done(tag, exp, 5);
    tick(); tick();
  endtask

  initial begin
    int cnt;
    reset = 1'b0; start = 1'b0; Signal = '0; dataA = '0; shamt = '0;
    tick();
    chk_en = 1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", dataOut, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    op("t1", 32'h0000_0001, 6'd31, 32'h8000_0000);
    op("t2a", 32'hFFFF_FFFF, 6'd4, 32'hFFFF_FFF0);
    op("t2b", 32'hFFFF_FFFF, 6'd0, 32'hFFFF_FFFF);
    op("t3", 32'h1234_5678, 6'b100011, 32'h91A2_B3C0);

    // Mid-op stimulus is ignored.
    start = 1'b1; dataA = 32'h0000_00FF; shamt = 6'd8;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; dataA = 32'hDEAD_BEEF; shamt = 6'd1;
    tick();
    start = 1'b0;
    wait_done("t4", 32'h0000_FF00, 3);
    tick(); tick();

    // Wrong function code never starts an op.
    start = 1'b1; Signal = 6'b000010; dataA = 32'h5; shamt = 6'd1;
    tick();
    start = 1'b0; Signal = 6'b000000;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("t4_badsig", 32'(cnt), 32'd0);
    tick();

    // Reset in flight aborts without a done pulse.
    start = 1'b1; dataA = 32'hCAFE_0001; shamt = 6'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_out", dataOut, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("t5_nodone", 32'(cnt), 32'd0);
    tick();
    op("t5b", 32'h0000_0003, 6'd2, 32'h0000_000C);

    // start held high: back-to-back ops, second operand picked up on re-accept.
    start = 1'b1; dataA = 32'h0000_0F0F; shamt = 6'd12;
    tick();
    dataA = 32'h8001_0001; shamt = 6'd17;
    wait_done("t6a", 32'h00F0_F000, 5);
    wait_done("t6b", 32'h0002_0000, -1);
    start = 1'b0;
    tick(); tick(); tick();

    // Randomized traffic, including held start, bad codes and occasional reset.
    for (int i = 0; i < 600; i++) begin
      start  = 1'($urandom_range(0, 1));
      Signal = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b000000;
      dataA  = $urandom;
      shamt  = 6'($urandom_range(0, 63));
      reset  = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1; start = 1'b0;
    repeat (10) tick();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
